// File: rtl/hc161_counter_pkg.sv
// Shared constants, operating-mode encoding and terminal-value helper for the
// hc161_counter presettable binary counter.
package hc161_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_RESET = 2'd3
  } mode_e;

  // All-ones value for a counter of the given width (widths up to 64 bits).
  function automatic logic [63:0] term_value(input int width);
    term_value = (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/hc161_counter.sv
// Synchronous presettable binary counter, function-compatible with the 74HC161:
// synchronous reset, parallel load, dual count enables and ripple-carry TC.
module hc161_counter
  import hc161_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             PE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  localparam logic [WIDTH-1:0] TERM_VALUE = WIDTH'(term_value(WIDTH));

  mode_e            mode;
  logic [WIDTH-1:0] q_next;

  // Priority decode: reset over load over count; later controls are never
  // examined once an earlier one selects, so an X there cannot leak into Q.
  always_comb begin
    mode = MODE_HOLD;
    if (CR) begin
      mode = MODE_RESET;
    end else if (!PE) begin
      mode = MODE_LOAD;
    end else if (CEP && CET) begin
      mode = MODE_COUNT;
    end else begin
      mode = MODE_HOLD;
    end
  end

  // Next counter value for the selected mode.
  always_comb begin
    q_next = Q;
    case (mode)
      MODE_RESET: q_next = '0;
      MODE_LOAD:  q_next = D;
      MODE_COUNT: q_next = Q + WIDTH'(1'b1);
      MODE_HOLD:  q_next = Q;
      default:    q_next = Q;
    endcase
  end

  // Counter state register.
  always_ff @(posedge CP) begin
    Q <= q_next;
  end

  // Ripple carry stays combinational on live CET so cascaded stages see it
  // within the same cycle.
  always_comb begin
    TC = CET && (Q == TERM_VALUE);
  end

endmodule

// File: tb/tb_hc161_counter.sv
// Self-checking bench for hc161_counter: expected Q values are queued when a
// cycle is driven and compared after the clock edge that produces them.
module tb_hc161_counter;

  logic       clk;
  logic       cr;
  logic       cep;
  logic       cet;
  logic       pe;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;

  int         checks;
  int         failures;
  logic [3:0] model_q;
  logic [3:0] exp_queue[$];

  hc161_counter #(.WIDTH(4)) dut (
    .CP (clk),
    .CR (cr),
    .CEP(cep),
    .CET(cet),
    .PE (pe),
    .D  (d),
    .Q  (q),
    .TC (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, queue the expected state, then
  // compare Q and TC shortly after the rising edge.
  task automatic step(input string tag, input logic s_cr, input logic s_pe,
                      input logic s_cep, input logic s_cet, input logic [3:0] s_d);
    logic [3:0] exp;
    @(negedge clk);
    cr = s_cr; pe = s_pe; cep = s_cep; cet = s_cet; d = s_d;
    if (s_cr === 1'b1)                      model_q = 4'h0;
    else if (s_pe === 1'b0)                 model_q = s_d;
    else if (s_cep === 1'b1 && s_cet === 1'b1) model_q = model_q + 4'h1;
    exp_queue.push_back(model_q);
    @(posedge clk);
    #1;
    if (exp_queue.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp = exp_queue.pop_front();
      check_eq({tag, "_q"}, {28'd0, q}, {28'd0, exp});
      check_eq({tag, "_tc"}, {31'd0, tc}, {31'd0, (s_cet === 1'b1) && (exp == 4'hF)});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_q = 4'h0;
    cr = 1'b1; pe = 1'b1; cep = 1'b1; cet = 1'b1; d = 4'h0;

    // Reset held for several edges while counting is enabled
    for (int i = 0; i < 5; i++) step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) step("count_after_reset", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);

    // Load mid-count, then resume
    step("load_mid", 1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
    step("count_after_load", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    step("count_after_load", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    step("load_disabled", 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);

    // Terminal count and wrap from D=1
    step("load_one", 1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
    for (int i = 0; i < 14; i++) step("count_to_tc", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    step("wrap", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);

    // Enable hold on each enable separately, then resume
    for (int i = 0; i < 5; i++) step("count_to_5", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) step("hold_cep", 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 2; i++) step("hold_cet", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step("resume", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);

    // TC gating by CET while Q sits at all ones
    step("load_ff", 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    step("hold_ff", 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    @(negedge clk);
    cet = 1'b0;
    #1;
    check_eq("tc_cet_drop", {31'd0, tc}, 32'd0);
    check_eq("q_cet_drop", {28'd0, q}, 32'hF);
    step("hold_ff_cet0", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step("wrap_from_ff", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);

    // Reset beats load; load follows once reset is released
    step("prio_reset", 1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
    step("prio_load", 1'b0, 1'b0, 1'b1, 1'b1, 4'h9);

    // Reset mid-count, counting resumes from zero
    step("count_pre_rst", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    step("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    step("count_post_rst", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);

    // Unknowns on controls the selected branch does not use
    step("load_x_en", 1'b0, 1'b0, 1'bx, 1'bx, 4'h3);
    step("count_x_d", 1'b0, 1'b1, 1'b1, 1'b1, 4'bxxxx);
    step("reset_x", 1'b1, 1'bx, 1'bx, 1'b0, 4'bxxxx);

    // Random mix weighted toward counting
    for (int i = 0; i < 60; i++) begin
      step("random",
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc161_counter.md
Name: hc161_counter

Overview:
- Synchronous presettable 4-bit binary counter, function-compatible with the 74HC161: parallel load, two count enables, ripple-carry terminal count.
- Reset is synchronous and active-high (see Ports), not the device's asynchronous active-low clear.
- Used as a general-purpose counting/prescaler element; cascadable through TC -> CET of the next stage.

Parameters:
- WIDTH, 4, counter and data width in bits; 4 gives the 74HC161 function.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- CR  input  1  reset; one clock; reset is synchronous and active-high.
- CEP  input  1  count enable, parallel; active-high.
- CET  input  1  count enable, trickle; active-high; also gates TC.
- PE  input  1  parallel enable (load), active-low, synchronous.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  counter state, registered.
- TC  output  1  terminal count, combinational.

Behaviour:
- All updates on rising edge of CP. Priority, highest first: CR, then PE, then count, then hold.
- CR=1 at edge: Q <= 0. Independent of PE, CEP, CET and D.
- CR=0, PE=0 at edge: Q <= D. Load ignores CEP/CET; load latency is one edge.
- CR=0, PE=1, CEP=1, CET=1 at edge: Q <= Q+1 modulo 2^WIDTH. All-ones wraps to 0.
- CR=0, PE=1, CEP=0 or CET=0: Q holds.
- TC = CET AND (Q == all ones); combinational from registered Q and live CET.
  - TC is unaffected by CEP and PE.
  - TC drops immediately when CET falls, even while Q stays at all ones.
- Power-up state is unspecified until first reset edge; after reset Q=0 and TC=0.
- Reset mid-count or mid-load: reset wins on that edge; counting resumes on the first edge with CR=0.
- Load of all ones with CET=1: TC asserts on the cycle after the load edge.
- No X-propagation tricks: an X on an unused control in the selected branch must not corrupt Q.

Decomposition:
- Package constants: default width (4) and the all-ones terminal value helper.
- Single module; no sub-module needed.
- For cascading, the integrator chains TC(n) -> CET(n+1) and drives CEP in parallel at the top level.

Test Plan:
- Reset: CR=1 for 5 edges with CEP=CET=1, PE=1 -> Q=0, TC=0. Release CR -> Q counts 1, 2, 3 on successive edges.
- Load: D=4'h1, PE=0 for one edge mid-count -> Q=1 on that edge. PE=1 -> Q=2, 3, ... Also check that load happens with CEP=CET=0.
- Terminal count/wrap, D=1 start: Q reaches 15 -> TC=1 while CET=1. Next edge -> Q=0, TC=0.
- Enable hold:
  - CEP=0 for 3 edges -> Q frozen.
  - CET=0 for 2 edges -> Q frozen.
  - Re-enable -> count resumes from the held value.
- TC gating: hold Q=15 with CEP=0, CET=1 -> TC=1. Drop CET -> TC=0 combinationally, Q stays 15. Set CEP=CET=1 -> Q=0 next edge.
- Priority: assert CR=1 and PE=0 on the same edge with D=4'h9 -> Q=0. Then CR=0, PE=0 -> Q=9.
